// File: rtl/ysyx_ifu_pkg.sv
// ysyx_ifu_pkg: shared FSM states, address-split width helpers and a pc field extractor
package ysyx_ifu_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP, DRAIN} state_t;
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - $clog2(sets) - $clog2(line_words) - 2;
  endfunction
  function automatic logic [63:0] pc_field(input logic [63:0] pc, input int lsb, input int w);
    return (pc >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/ysyx_l1i_array.sv
// ysyx_l1i_array: direct-mapped tag/valid/data storage, combinational read, one write port, global invalidate
module ysyx_l1i_array #(
  parameter int DATA_W = 32,
  parameter int SETS = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W = 24,
  parameter int IDX_W = 4,
  parameter int OFF_B = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  output logic              hit,
  input  logic [OFF_B-1:0]  rd_off,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [OFF_B-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic              vld_we,
  input  logic              vld_in,
  input  logic              inv_all
);
  localparam int AW = $clog2(SETS * LINE_WORDS);
  logic [DATA_W-1:0] data [SETS*LINE_WORDS];
  logic [TAG_W-1:0]  tags [SETS];
  logic [SETS-1:0]   valid;
  logic [AW-1:0]     rd_a, wr_a;
  assign rd_a = AW'(int'(idx) * LINE_WORDS + int'(rd_off));
  assign wr_a = AW'(int'(idx) * LINE_WORDS + int'(wr_off));
  assign rd_data = data[rd_a];
  assign hit = valid[idx] && tags[idx] == tag;
  always_ff @(posedge clk) begin
    if (wr_en) data[wr_a] <= wr_data;
    if (tag_we) tags[idx] <= tag;
  end
  // invalidate-all beats a same-cycle valid write so fence_i always wins
  always_ff @(posedge clk) begin
    if (rst || inv_all) valid <= '0;
    else if (vld_we) valid[idx] <= vld_in;
  end
endmodule

// File: rtl/ysyx_ifu_l1i.sv
// ysyx_ifu_l1i: fetch unit with direct-mapped L1 I-cache and word-by-word line refill
// Optional perf_hit/perf_miss counters when YSYX_IFU_L1I_PERF_EN is defined.
module ysyx_ifu_l1i
  import ysyx_ifu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              kill,
  input  logic              fence_i,
  output logic              bus_arvalid,
  input  logic              bus_arready,
  output logic [ADDR_W-1:0] bus_araddr,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef YSYX_IFU_L1I_PERF_EN
  ,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss
`endif
);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int OFF_B = OFF_W > 0 ? OFF_W : 1;
  state_t state, nxt;
  logic [ADDR_W-1:0] pc_q;
  logic [OFF_B-1:0]  k, off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              poison, hit, last, wr_en, tag_we, vld_we, vld_in;
  assign tag = TAG_W'(pc_field(64'(pc_q), ADDR_W - TAG_W, TAG_W));
  assign idx = IDX_W'(pc_field(64'(pc_q), OFF_W + 2, IDX_W));
  assign off = OFF_B'(pc_field(64'(pc_q), 2, OFF_W));
  assign last = k == OFF_B'(LINE_WORDS - 1);
  assign out_pc = pc_q;
  assign bus_araddr = {pc_q[ADDR_W-1:OFF_W+2], {(OFF_W + 2){1'b0}}} | (ADDR_W'(k) << 2);
  ysyx_l1i_array #(
    .DATA_W(DATA_W), .SETS(SETS), .LINE_WORDS(LINE_WORDS),
    .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_B(OFF_B)
  ) u_array (
    .clk(clk), .rst(rst), .idx(idx), .tag(tag), .hit(hit),
    .rd_off(off), .rd_data(out_inst),
    .wr_en(wr_en), .wr_off(k), .wr_data(bus_rdata),
    .tag_we(tag_we), .vld_we(vld_we), .vld_in(vld_in), .inv_all(fence_i)
  );
  always_comb begin
    nxt = state;
    req_ready = 1'b0;
    out_valid = 1'b0;
    bus_arvalid = 1'b0;
    wr_en = 1'b0;
    tag_we = 1'b0;
    vld_we = 1'b0;
    vld_in = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = LOOKUP;
      end
      LOOKUP: begin
        if (kill) nxt = IDLE;
        else if (hit) begin
          out_valid = 1'b1;
          nxt = out_ready ? IDLE : RESP;
        end else begin
          vld_we = 1'b1;
          nxt = REFILL_AR;
        end
      end
      REFILL_AR: begin
        bus_arvalid = !kill;
        if (kill) nxt = IDLE;
        else if (bus_arready) nxt = REFILL_R;
      end
      REFILL_R: begin
        if (bus_rvalid) begin
          wr_en = 1'b1;
          tag_we = !kill && last;
          vld_we = !kill && last;
          vld_in = !poison;
          nxt = kill ? IDLE : last ? RESP : REFILL_AR;
        end else if (kill) nxt = DRAIN;
      end
      RESP: begin
        out_valid = !kill;
        if (kill || out_ready) nxt = IDLE;
      end
      DRAIN: if (bus_rvalid) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      poison <= 1'b0;
    end else begin
      state <= nxt;
      if (req_ready && req_valid) pc_q <= req_pc;
      k <= state == LOOKUP ? '0 : (state == REFILL_R && bus_rvalid) ? k + 1'b1 : k;
      poison <= state == LOOKUP ? 1'b0 : poison | (fence_i && (state == REFILL_AR || state == REFILL_R));
    end
  end
`ifdef YSYX_IFU_L1I_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit <= '0;
      perf_miss <= '0;
    end else begin
      perf_hit <= perf_hit + 32'(state == LOOKUP && hit && perf_hit != '1);
      perf_miss <= perf_miss + 32'(state == LOOKUP && !hit && perf_miss != '1);
    end
  end
`endif
endmodule
